// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-requester memory port arbiter.
//   - default bus widths
//   - arbiter state and requester enums
//   - request payload struct and its normalisation helper
package mem_arbiter_pkg;

    localparam int unsigned ARB_ADDR_W = 32;
    localparam int unsigned ARB_DATA_W = 32;
    localparam int unsigned ARB_BE_W   = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_CORE = 2'd1,
        BUSY_DBG  = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } requester_e;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_BE_W-1:0]   byteen;
    } req_t;

    // A request with both read and write raised is issued as a write.
    function automatic req_t to_cmd(input req_t r);
        req_t c;
        c      = r;
        c.read = r.read & ~r.write;
        return c;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one memory-style request/completion port.
//   master: drives read/write/addr/wdata/byteen, receives rdata and
//           the complete_read/complete_write pulses.
//   slave : the opposite direction.
// The arbiter is a slave to the core and debug ports and a master to memory.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned DATA_W = ARB_DATA_W
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   byteen;
    logic [DATA_W-1:0] rdata;
    logic              complete_read;
    logic              complete_write;

    modport master (
        output read, write, addr, wdata, byteen,
        input  rdata, complete_read, complete_write
    );

    modport slave (
        input  read, write, addr, wdata, byteen,
        output rdata, complete_read, complete_write
    );

endinterface

// File: rtl/arb_rr2.sv
// arb_rr2: combinational 2-way round-robin pick.
//   req[0] = core, req[1] = dbg
//   last_grant : requester that owned the previous transaction
//   lock       : only dbg is eligible while high
//   gnt_c      : one-hot grant (bit 0 core, bit 1 dbg), zero if nobody eligible
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  requester_e last_grant,
    input  logic       lock,
    output logic [1:0] gnt_c
);

    logic [1:0] eligible;

    // On a tie the requester not granted last wins.
    always_comb begin
        eligible = lock ? {req[1], 1'b0} : req;
        gnt_c    = 2'b00;
        case (eligible)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = (last_grant == REQ_CORE) ? 2'b10 : 2'b01;
            default: gnt_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the core and the debug module.
//   clk, rst  : clock, synchronous active-high reset
//   core_bus  : core requester port (slave)
//   dbg_bus   : debug requester port (slave)
//   mem_bus   : memory controller port (master); command fields registered
//   dbg_lock  : while high only dbg may be granted new transactions
//   grant_dbg : current or last owner is dbg
// One transaction outstanding at a time; completions and read data are routed
// combinationally from memory to the owning requester.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ARB_ADDR_W,
    parameter int unsigned DATA_W = ARB_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_arbiter_if.slave         core_bus,
    mem_arbiter_if.slave         dbg_bus,
    mem_arbiter_if.master        mem_bus,
    input  logic                 dbg_lock,
    output logic                 grant_dbg
);

    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e state_q,      state_d;
    requester_e last_grant_q, last_grant_d;
    req_t       cmd_q,        cmd_d;
    logic       grant_dbg_q,  grant_dbg_d;

    req_t       core_req;
    req_t       dbg_req;
    logic [1:0] req_vec;
    logic [1:0] gnt_c;
    logic       mem_done_c;
    logic       core_cr_c, core_cw_c, dbg_cr_c, dbg_cw_c;

    // Requester payloads in package struct form.
    always_comb begin
        core_req = '{read:   core_bus.read,
                     write:  core_bus.write,
                     addr:   ARB_ADDR_W'(core_bus.addr),
                     wdata:  ARB_DATA_W'(core_bus.wdata),
                     byteen: ARB_BE_W'(core_bus.byteen)};
        dbg_req  = '{read:   dbg_bus.read,
                     write:  dbg_bus.write,
                     addr:   ARB_ADDR_W'(dbg_bus.addr),
                     wdata:  ARB_DATA_W'(dbg_bus.wdata),
                     byteen: ARB_BE_W'(dbg_bus.byteen)};
        req_vec  = {dbg_req.read | dbg_req.write, core_req.read | core_req.write};
    end

    arb_rr2 u_rr (
        .req        (req_vec),
        .last_grant (last_grant_q),
        .lock       (dbg_lock),
        .gnt_c      (gnt_c)
    );

    // A completion only counts when it matches the outstanding command type.
    assign mem_done_c = (cmd_q.read  & mem_bus.complete_read) |
                        (cmd_q.write & mem_bus.complete_write);

    // Next-state, grant capture and completion routing.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_d        = cmd_q;
        grant_dbg_d  = grant_dbg_q;
        core_cr_c    = 1'b0;
        core_cw_c    = 1'b0;
        dbg_cr_c     = 1'b0;
        dbg_cw_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_c[0]) begin
                    cmd_d       = to_cmd(core_req);
                    grant_dbg_d = 1'b0;
                    state_d     = BUSY_CORE;
                end else if (gnt_c[1]) begin
                    cmd_d       = to_cmd(dbg_req);
                    grant_dbg_d = 1'b1;
                    state_d     = BUSY_DBG;
                end
            end
            BUSY_CORE: begin
                core_cr_c = cmd_q.read  & mem_bus.complete_read;
                core_cw_c = cmd_q.write & mem_bus.complete_write;
                if (mem_done_c) begin
                    cmd_d.read   = 1'b0;
                    cmd_d.write  = 1'b0;
                    last_grant_d = REQ_CORE;
                    state_d      = IDLE;
                end
            end
            BUSY_DBG: begin
                dbg_cr_c = cmd_q.read  & mem_bus.complete_read;
                dbg_cw_c = cmd_q.write & mem_bus.complete_write;
                if (mem_done_c) begin
                    cmd_d.read   = 1'b0;
                    cmd_d.write  = 1'b0;
                    last_grant_d = REQ_DBG;
                    state_d      = IDLE;
                end
            end
            default: begin
                cmd_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to dbg so core wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_DBG;
            cmd_q        <= '0;
            grant_dbg_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_q        <= cmd_d;
            grant_dbg_q  <= grant_dbg_d;
        end
    end

    assign mem_bus.read   = cmd_q.read;
    assign mem_bus.write  = cmd_q.write;
    assign mem_bus.addr   = ADDR_W'(cmd_q.addr);
    assign mem_bus.wdata  = DATA_W'(cmd_q.wdata);
    assign mem_bus.byteen = BE_W'(cmd_q.byteen);
    assign grant_dbg      = grant_dbg_q;

    assign core_bus.rdata          = mem_bus.rdata;
    assign core_bus.complete_read  = core_cr_c;
    assign core_bus.complete_write = core_cw_c;
    assign dbg_bus.rdata           = mem_bus.rdata;
    assign dbg_bus.complete_read   = dbg_cr_c;
    assign dbg_bus.complete_write  = dbg_cw_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Grants are checked against a queue of expected commands filled when the
// requests are driven; completion routing is checked inline.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic dbg_lock;
    logic grant_dbg;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) core_bus ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_bus ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .core_bus  (core_bus),
        .dbg_bus   (dbg_bus),
        .mem_bus   (mem_bus),
        .dbg_lock  (dbg_lock),
        .grant_dbg (grant_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          owner_dbg;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] byteen;
    } exp_t;

    typedef struct {
        logic          c_rd, c_wr, d_rd, d_wr, lock;
        logic [AW-1:0] c_addr, d_addr;
        logic [DW-1:0] c_wdata, d_wdata, rdata;
        logic [BW-1:0] c_be, d_be;
        int            lat;
        logic          exp_grant, exp_dbg, exp_wr;
    } vec_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_active = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] done_bits();
        return {core_bus.complete_read, core_bus.complete_write,
                dbg_bus.complete_read, dbg_bus.complete_write};
    endfunction

    function automatic logic active();
        return mem_bus.read | mem_bus.write;
    endfunction

    task automatic drop_all();
        core_bus.read  = 1'b0;
        core_bus.write = 1'b0;
        dbg_bus.read   = 1'b0;
        dbg_bus.write  = 1'b0;
    endtask

    task automatic push_exp(input logic owner_dbg, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [BW-1:0] be);
        exp_t e;
        e.owner_dbg = owner_dbg;
        e.wr        = wr;
        e.addr      = addr;
        e.wdata     = wdata;
        e.byteen    = be;
        sb_q.push_back(e);
    endtask

    // Tick until a memory command appears, bounded.
    task automatic wait_active(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!active() && cnt < 6);
        if (!active()) check("wait_active_timeout", 64'(active()), 64'd1);
    endtask

    // Scoreboard monitor: each new memory command must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (active() && !prev_active) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: addr 0x%0h got no expected entry (t=%0t)",
                         mem_bus.addr, $time);
            end else begin
                e = sb_q.pop_front();
                check("grant_owner", 64'(grant_dbg), 64'(e.owner_dbg));
                check("mem_write",   64'(mem_bus.write), 64'(e.wr));
                check("mem_read",    64'(mem_bus.read), 64'(!e.wr));
                check("mem_addr",    64'(mem_bus.addr), 64'(e.addr));
                check("mem_wdata",   64'(mem_bus.wdata), 64'(e.wdata));
                check("mem_byteen",  64'(mem_bus.byteen), 64'(e.byteen));
            end
        end
        prev_active = active();
    end

    function automatic vec_t mk(input logic c_rd, input logic c_wr, input logic d_rd,
                                input logic d_wr, input logic lock,
                                input logic [AW-1:0] c_addr, input logic [AW-1:0] d_addr,
                                input logic [BW-1:0] d_be, input int lat,
                                input logic [DW-1:0] rdata, input logic exp_grant,
                                input logic exp_dbg, input logic exp_wr);
        vec_t v;
        v.c_rd = c_rd; v.c_wr = c_wr; v.d_rd = d_rd; v.d_wr = d_wr; v.lock = lock;
        v.c_addr = c_addr; v.d_addr = d_addr;
        v.c_wdata = 32'hC000_0000 ^ c_addr;
        v.d_wdata = 32'hD000_0000 ^ d_addr;
        v.c_be = 4'hF; v.d_be = d_be;
        v.lat = lat; v.rdata = rdata;
        v.exp_grant = exp_grant; v.exp_dbg = exp_dbg; v.exp_wr = exp_wr;
        return v;
    endfunction

    // One transaction from IDLE back to IDLE.
    task automatic do_vec(input vec_t v, input int idx);
        logic [3:0] exp_done;
        core_bus.read  = v.c_rd;   core_bus.write  = v.c_wr;
        core_bus.addr  = v.c_addr; core_bus.wdata  = v.c_wdata; core_bus.byteen = v.c_be;
        dbg_bus.read   = v.d_rd;   dbg_bus.write   = v.d_wr;
        dbg_bus.addr   = v.d_addr; dbg_bus.wdata   = v.d_wdata; dbg_bus.byteen  = v.d_be;
        dbg_lock       = v.lock;
        if (v.exp_grant)
            push_exp(v.exp_dbg, v.exp_wr, v.exp_dbg ? v.d_addr : v.c_addr,
                     v.exp_dbg ? v.d_wdata : v.c_wdata, v.exp_dbg ? v.d_be : v.c_be);
        tick();
        check($sformatf("v%0d_grant", idx), 64'(active()), 64'(v.exp_grant));
        if (!v.exp_grant) begin
            tick();
            check($sformatf("v%0d_still_no_grant", idx), 64'(active()), 64'd0);
            drop_all();
            tick();
            return;
        end
        for (int i = 0; i < v.lat; i++) begin
            #1;
            check($sformatf("v%0d_no_early_done", idx), 64'(done_bits()), 64'd0);
            tick();
            check($sformatf("v%0d_cmd_held", idx), 64'(active()), 64'd1);
        end
        mem_bus.rdata = v.rdata;
        if (v.exp_wr) mem_bus.complete_write = 1'b1;
        else          mem_bus.complete_read  = 1'b1;
        #1;
        exp_done = v.exp_dbg ? {2'b00, !v.exp_wr, v.exp_wr} : {!v.exp_wr, v.exp_wr, 2'b00};
        check($sformatf("v%0d_done_route", idx), 64'(done_bits()), 64'(exp_done));
        if (!v.exp_wr)
            check($sformatf("v%0d_rdata", idx),
                  64'(v.exp_dbg ? dbg_bus.rdata : core_bus.rdata), 64'(v.rdata));
        tick();
        mem_bus.complete_read  = 1'b0;
        mem_bus.complete_write = 1'b0;
        drop_all();
        check($sformatf("v%0d_idle_after_done", idx), 64'(active()), 64'd0);
        tick();
    endtask

    vec_t vecs[10];

    initial begin
        int cnt;

        // core first on tie after reset, lock gating, read+write issued as write
        vecs[0] = mk(1,0,0,0,0, 32'h100, 32'h0,    4'hF, 3, 32'hDEADBEEF, 1,0,0);
        vecs[1] = mk(0,0,1,1,0, 32'h0,   32'h2000, 4'b0011, 1, 32'h0,      1,1,1);
        vecs[2] = mk(1,0,1,0,0, 32'h10,  32'h20,   4'hF, 0, 32'h11112222,  1,0,0);
        vecs[3] = mk(1,0,1,0,0, 32'h10,  32'h20,   4'hF, 0, 32'h33334444,  1,1,0);
        vecs[4] = mk(0,1,0,1,1, 32'h30,  32'h40,   4'h5, 0, 32'h0,         1,1,1);
        vecs[5] = mk(0,1,0,1,1, 32'h30,  32'h44,   4'hA, 2, 32'h0,         1,1,1);
        vecs[6] = mk(1,0,0,0,1, 32'h50,  32'h0,    4'hF, 0, 32'h0,         0,0,0);
        vecs[7] = mk(0,1,0,1,0, 32'h60,  32'h64,   4'hF, 0, 32'h0,         1,0,1);
        vecs[8] = mk(1,1,0,0,0, 32'h70,  32'h0,    4'hF, 1, 32'h0,         1,0,1);
        vecs[9] = mk(1,0,0,1,0, 32'h80,  32'h84,   4'h3, 0, 32'h0,         1,1,1);

        rst = 1'b1;
        dbg_lock = 1'b0;
        drop_all();
        core_bus.addr = '0; core_bus.wdata = '0; core_bus.byteen = '0;
        dbg_bus.addr  = '0; dbg_bus.wdata  = '0; dbg_bus.byteen  = '0;
        mem_bus.rdata = '0;
        mem_bus.complete_read  = 1'b0;
        mem_bus.complete_write = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_mem_cmd",    64'({mem_bus.read, mem_bus.write}), 64'd0);
        check("rst_mem_addr",   64'(mem_bus.addr), 64'd0);
        check("rst_mem_wdata",  64'(mem_bus.wdata), 64'd0);
        check("rst_mem_byteen", 64'(mem_bus.byteen), 64'd0);
        check("rst_grant_dbg",  64'(grant_dbg), 64'd0);
        rst = 1'b0;
        mem_bus.complete_read = 1'b1;
        #1;
        check("idle_done_gated", 64'(done_bits()), 64'd0);
        tick();
        mem_bus.complete_read = 1'b0;

        foreach (vecs[i]) do_vec(vecs[i], i);

        // both hold reads: strict alternation, 2 cycles per transaction
        core_bus.read = 1'b1; core_bus.addr = 32'h300;
        dbg_bus.read  = 1'b1; dbg_bus.addr  = 32'h400;
        core_bus.wdata = 32'h1; dbg_bus.wdata = 32'h2;
        core_bus.byteen = 4'hF; dbg_bus.byteen = 4'hF;
        for (int k = 0; k < 4; k++)
            push_exp(k % 2 == 1, 1'b0, (k % 2 == 1) ? 32'h400 : 32'h300,
                     (k % 2 == 1) ? 32'h2 : 32'h1, 4'hF);
        for (int k = 0; k < 4; k++) begin
            wait_active(cnt);
            check($sformatf("rr%0d_spacing", k), 64'(cnt), 64'd1);
            mem_bus.complete_read = 1'b1;
            mem_bus.rdata = 32'hA000_0000 + 32'(k);
            #1;
            check($sformatf("rr%0d_done_route", k), 64'(done_bits()),
                  (k % 2 == 1) ? 64'b0010 : 64'b1000);
            tick();
            mem_bus.complete_read = 1'b0;
        end
        drop_all();
        tick();
        tick();

        // core drops its read mid-transaction
        core_bus.read = 1'b1; core_bus.addr = 32'h500;
        core_bus.wdata = 32'h55; core_bus.byteen = 4'h9;
        push_exp(1'b0, 1'b0, 32'h500, 32'h55, 4'h9);
        tick();
        check("drop_grant", 64'(active()), 64'd1);
        core_bus.read = 1'b0;
        tick();
        check("drop_hold1", 64'(mem_bus.read), 64'd1);
        tick();
        check("drop_hold2", 64'(mem_bus.read), 64'd1);
        mem_bus.complete_read = 1'b1;
        mem_bus.rdata = 32'hA5A5_5A5A;
        #1;
        check("drop_done_route", 64'(done_bits()), 64'b1000);
        check("drop_rdata", 64'(core_bus.rdata), 64'hA5A5_5A5A);
        tick();
        mem_bus.complete_read = 1'b0;
        tick();

        // wrong completion type is ignored
        dbg_bus.read = 1'b1; dbg_bus.addr = 32'h600;
        dbg_bus.wdata = 32'h66; dbg_bus.byteen = 4'h6;
        push_exp(1'b1, 1'b0, 32'h600, 32'h66, 4'h6);
        tick();
        check("wrong_grant", 64'(active()), 64'd1);
        mem_bus.complete_write = 1'b1;
        #1;
        check("wrong_type_ignored", 64'(done_bits()), 64'd0);
        tick();
        mem_bus.complete_write = 1'b0;
        check("wrong_type_hold", 64'(mem_bus.read), 64'd1);
        mem_bus.complete_read = 1'b1;
        #1;
        check("wrong_then_right", 64'(done_bits()), 64'b0010);
        tick();
        mem_bus.complete_read = 1'b0;
        drop_all();
        tick();

        // reset in BUSY_DBG with completion pending
        dbg_bus.read = 1'b1; dbg_bus.addr = 32'h700;
        dbg_bus.wdata = 32'h77; dbg_bus.byteen = 4'h7;
        push_exp(1'b1, 1'b0, 32'h700, 32'h77, 4'h7);
        tick();
        check("rstbusy_grant_dbg", 64'(grant_dbg), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dbg_bus.read = 1'b0;
        check("rstbusy_cmd_off", 64'({mem_bus.read, mem_bus.write}), 64'd0);
        check("rstbusy_grant_clr", 64'(grant_dbg), 64'd0);
        check("rstbusy_addr_clr", 64'(mem_bus.addr), 64'd0);
        mem_bus.complete_read = 1'b1;
        #1;
        check("rstbusy_late_done", 64'(done_bits()), 64'd0);
        tick();
        mem_bus.complete_read = 1'b0;
        core_bus.read = 1'b1; core_bus.addr = 32'h800;
        core_bus.wdata = 32'h88; core_bus.byteen = 4'h8;
        push_exp(1'b0, 1'b0, 32'h800, 32'h88, 4'h8);
        tick();
        check("rstbusy_core_grant", 64'(active()), 64'd1);
        mem_bus.complete_read = 1'b1;
        mem_bus.rdata = 32'h1234_5678;
        #1;
        check("rstbusy_core_done", 64'(done_bits()), 64'b1000);
        tick();
        mem_bus.complete_read = 1'b0;
        drop_all();
        tick();
        tick();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory port arbiter between the core and the debug module. It shares the single system memory port between the core's load/store/fetch traffic (driven by the microcoded control unit) and the debug module's abstract memory accesses. It sits between those two masters and the memory controller. At most one transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports (x ∈ {core, dbg}). One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- x_read  in  1  read request, held until x_complete_read
- x_write  in  1  write request, held until x_complete_write
- x_addr  in  ADDR_W  request address
- x_wdata  in  DATA_W  write data
- x_byteen  in  DATA_W/8  write byte enables
- x_rdata  out  DATA_W  read data, valid with x_complete_read
- x_complete_read  out  1  one-cycle read-done pulse
- x_complete_write  out  1  one-cycle write-done pulse
- dbg_lock  in  1  while high, only dbg may be granted new transactions
- mem_read / mem_write  out  1  command to memory, level-held until completion
- mem_addr / mem_wdata / mem_byteen  out  ADDR_W / DATA_W / DATA_W/8  registered command fields
- mem_rdata  in  DATA_W  read data from memory
- mem_complete_read / mem_complete_write  in  1  memory completion pulses
- grant_dbg  out  1  current or last owner is dbg (status)

## Operation
- States: IDLE, BUSY_CORE, BUSY_DBG.
- IDLE: a requester is active if its read or write is high. Winner selection:
  - dbg_lock=1: only dbg is eligible.
  - Only one active: that one wins.
  - Both active: round-robin; the requester not granted last wins.
- Winner's addr, wdata and byteen are registered into the mem_* outputs. If both read and write are high, it is a write. State moves to BUSY_x.
- BUSY_x: mem_read/mem_write stay high. mem_complete_* is routed combinationally to x_complete_*, and mem_rdata to x_rdata. The other requester sees zero completions. On completion, mem_read/mem_write drop at the next edge, last_grant updates and the state returns to IDLE.
- Requester dropping its request mid-transaction: the transaction still completes and the completion is still routed to it.
- A completion of the wrong type (e.g. mem_complete_write during a read) is ignored; the state holds.
- dbg_lock rising during BUSY_CORE does not abort the core transaction.
- Reset values:
  - All outputs 0 (x_rdata follows mem_rdata but is only qualified by completions).
  - State IDLE.
  - last_grant = dbg, so core wins the first tie.

## Timing
- Request high at edge N in IDLE: mem command is visible after edge N, i.e. one cycle of arbitration latency.
- Completion in cycle M: the requester sees it in the same cycle M. The next grant can be issued at edge M+1, with the command visible in cycle M+2.
- Back-to-back from one requester: minimum 2 cycles per transaction when memory completes in the first busy cycle.
- Reset mid-transaction: the next edge forces IDLE and mem_read=mem_write=0. A pending memory completion after reset is ignored.
- Completion never coincides with grant, because completion is only sampled in BUSY.

## Structure
- Package mem_arbiter_pkg holds:
  - enum arb_state_e {IDLE, BUSY_CORE, BUSY_DBG}
  - enum requester_e {REQ_CORE, REQ_DBG}
  - request struct {read, write, addr, wdata, byteen}
- Sub-module arb_rr2: 2-way round-robin pick from (req[1:0], last_grant, lock) to a one-hot grant. Purely combinational; last_grant is registered in mem_arbiter.

## Test plan
- Core read 0x100 alone; memory completes 3 cycles later with 0xDEADBEEF → core_rdata=0xDEADBEEF with core_complete_read pulse; dbg sees no pulse; IDLE one cycle after completion.
- Core and dbg both request after reset → core granted first, then dbg, then core again while both stay high; grants strictly alternate.
- dbg_lock=1 with core and dbg both writing → only dbg is granted (repeatedly); core is granted only after dbg_lock falls.
- dbg write 0x2000, byteen=4'b0011, read=write=1 → mem_write=1, mem_read=0, mem_byteen=0011 until completion.
- Core deasserts its read in BUSY_CORE → mem_read is held; core_complete_read still pulses on memory completion.
- rst asserted in BUSY_DBG with completion pending → outputs 0 after the edge; a later mem_complete_read produces no requester pulse; a new core request is granted normally.
